// File: rtl/display_arbiter_pkg.sv
// Shared display codes, FSM states and limits for the display arbiter.
package display_arbiter_pkg;

  localparam int unsigned CONTR_POS = 0;
  localparam int unsigned CONTR_NEG = 1;
  localparam int unsigned CONTR_ERR = 2;
  localparam int unsigned CONTR_DOT = 4;

  // Largest negative magnitude the display can render.
  localparam int unsigned NEG_LIMIT = 999;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHOW_OP,
    ST_SHOW_RES,
    ST_SHOW_ERR
  } state_e;

endpackage

// File: rtl/display_arbiter_hold_timer.sv
// Minimum-display hold counter: loads a value, counts down to zero and stays there.
module disp_hold_timer #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic          o_expired_c
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_expired_c = (r_cnt == '0);

endmodule

// File: rtl/display_arbiter.sv
// Arbitrates operand entry and ALU results onto a registered display interface,
// holding each result for a minimum time and buffering the newest operand meanwhile.
module display_arbiter
  import display_arbiter_pkg::*;
#(
  parameter int unsigned IND_ALU     = 11,
  parameter int unsigned C_ALU       = 3,
  parameter int unsigned HOLD_CYCLES = 10_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               op_valid,
  input  logic [IND_ALU-1:0] op_data,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic [IND_ALU:0]   res_data,
  input  logic               res_err,
  input  logic               res_frac,
  output logic [IND_ALU-1:0] disp_data,
  output logic [C_ALU-1:0]   disp_contr,
  output logic               show_res
);

  localparam int unsigned RW = IND_ALU + 1;
  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [IND_ALU-1:0] r_disp_data;
  logic [IND_ALU-1:0] w_disp_data_nxt;
  logic [C_ALU-1:0]   r_disp_contr;
  logic [C_ALU-1:0]   w_disp_contr_nxt;
  logic               r_show_res;
  logic               r_pend_valid;
  logic               w_pend_valid_nxt;
  logic [IND_ALU-1:0] r_pend_data;
  logic [IND_ALU-1:0] w_pend_data_nxt;

  logic               w_expired;
  logic               w_hold_open;
  logic               w_accept;
  logic               w_load;
  logic [CW-1:0]      w_load_val;
  logic               w_neg;
  logic [RW-1:0]      w_mag;
  logic               w_err;
  logic               w_showing;

  assign w_showing   = (r_state == ST_SHOW_RES) || (r_state == ST_SHOW_ERR);
  assign w_hold_open = !w_showing || w_expired;
  assign res_ready   = !clr && w_hold_open;
  assign w_accept    = res_valid && res_ready;

  // Magnitude kept at full result width so the most negative value still reads as too large.
  assign w_neg = res_data[RW-1];
  assign w_mag = w_neg ? RW'(-res_data) : res_data;
  assign w_err = res_err || (w_neg && ((w_mag > RW'(NEG_LIMIT)) || res_frac));

  // A clear reuses the load path with zero so the hold is dropped immediately.
  assign w_load     = clr || w_accept;
  assign w_load_val = clr ? '0 : CW'(HOLD_CYCLES - 1);

  disp_hold_timer #(
    .CW (CW)
  ) u_hold_timer (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_load_val  (w_load_val),
    .o_expired_c (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_disp_data  <= '0;
      r_disp_contr <= '0;
      r_show_res   <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_disp_data  <= w_disp_data_nxt;
      r_disp_contr <= w_disp_contr_nxt;
      r_show_res   <= (w_state_nxt == ST_SHOW_RES) || (w_state_nxt == ST_SHOW_ERR);
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_data  <= w_pend_data_nxt;
    end
  end

  // Priority: clear, accepted result, operand when display is free, operand buffered, pending drain.
  always_comb begin
    w_state_nxt      = r_state;
    w_disp_data_nxt  = r_disp_data;
    w_disp_contr_nxt = r_disp_contr;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_data_nxt  = r_pend_data;

    if (clr) begin
      w_state_nxt      = ST_IDLE;
      w_disp_data_nxt  = '0;
      w_disp_contr_nxt = C_ALU'(CONTR_POS);
      w_pend_valid_nxt = 1'b0;
    end else if (w_accept) begin
      if (w_err) begin
        w_state_nxt      = ST_SHOW_ERR;
        w_disp_data_nxt  = '0;
        w_disp_contr_nxt = C_ALU'(CONTR_ERR);
      end else if (w_neg) begin
        w_state_nxt      = ST_SHOW_RES;
        w_disp_data_nxt  = w_mag[IND_ALU-1:0];
        w_disp_contr_nxt = C_ALU'(CONTR_NEG);
      end else begin
        w_state_nxt      = ST_SHOW_RES;
        w_disp_data_nxt  = res_data[IND_ALU-1:0];
        w_disp_contr_nxt = res_frac ? C_ALU'(CONTR_DOT) : C_ALU'(CONTR_POS);
      end
      if (op_valid) begin
        w_pend_valid_nxt = 1'b1;
        w_pend_data_nxt  = op_data;
      end
    end else if (op_valid && w_hold_open) begin
      w_state_nxt      = ST_SHOW_OP;
      w_disp_data_nxt  = op_data;
      w_disp_contr_nxt = C_ALU'(CONTR_POS);
      w_pend_valid_nxt = 1'b0;
    end else if (op_valid) begin
      w_pend_valid_nxt = 1'b1;
      w_pend_data_nxt  = op_data;
    end else if (w_showing && w_expired && r_pend_valid) begin
      w_state_nxt      = ST_SHOW_OP;
      w_disp_data_nxt  = r_pend_data;
      w_disp_contr_nxt = C_ALU'(CONTR_POS);
      w_pend_valid_nxt = 1'b0;
    end
  end

  assign disp_data  = r_disp_data;
  assign disp_contr = r_disp_contr;
  assign show_res   = r_show_res;

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: directed table, corner sequences, random traffic vs. model.
module tb_display_arbiter;

  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        op_valid;
  logic [10:0] op_data;
  logic        res_valid;
  logic        res_ready;
  logic [11:0] res_data;
  logic        res_err;
  logic        res_frac;
  logic [10:0] disp_data;
  logic [2:0]  disp_contr;
  logic        show_res;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: what is on the display, whether it is a result, cycles left in hold, pending operand.
  int m_disp;
  int m_contr;
  bit m_show;
  int m_hold;
  int m_pend[$];

  typedef struct {
    bit ov;
    int od;
    bit rv;
    int rd;
    bit re;
    bit rf;
    int e_disp;
    int e_contr;
    bit e_show;
  } vec_t;

  vec_t tbl[$];
  int   low_cnt;
  int   x;

  display_arbiter #(
    .IND_ALU     (11),
    .C_ALU       (3),
    .HOLD_CYCLES (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .op_valid   (op_valid),
    .op_data    (op_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_err    (res_err),
    .res_frac   (res_frac),
    .disp_data  (disp_data),
    .disp_contr (disp_contr),
    .show_res   (show_res)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic bit m_ready();
    return !clr && (!m_show || m_hold == 0);
  endfunction

  task automatic model_reset();
    m_disp = 0; m_contr = 0; m_show = 0; m_hold = 0;
    m_pend.delete();
  endtask

  task automatic model_step();
    int v;
    bit open;
    open = !m_show || m_hold == 0;
    if (clr) begin
      model_reset();
    end else if (res_valid && open) begin
      v = int'($signed(res_data));
      if (res_err || v < -999 || (v < 0 && res_frac)) begin
        m_disp = 0; m_contr = 2;
      end else if (v < 0) begin
        m_disp = -v; m_contr = 1;
      end else begin
        m_disp = v; m_contr = res_frac ? 4 : 0;
      end
      m_show = 1;
      m_hold = H - 1;
      if (op_valid) begin
        m_pend.delete();
        m_pend.push_back(int'(op_data));
      end
    end else begin
      if (op_valid && open) begin
        m_disp = int'(op_data); m_contr = 0; m_show = 0;
        m_pend.delete();
      end else if (op_valid) begin
        m_pend.delete();
        m_pend.push_back(int'(op_data));
      end else if (m_show && m_hold == 0 && m_pend.size() > 0) begin
        m_disp = m_pend.pop_front(); m_contr = 0; m_show = 0;
      end
      if (m_hold > 0) m_hold--;
    end
  endtask

  task automatic drive(input bit ov, input int od, input bit rv, input int rd,
                       input bit re, input bit rf, input bit cl);
    op_valid = ov; op_data = 11'(od);
    res_valid = rv; res_data = 12'(rd);
    res_err = re; res_frac = rf; clr = cl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock: check ready before the edge, advance the model, check registered outputs after it.
  task automatic cycle();
    #1;
    chk("res_ready", int'(res_ready), int'(m_ready()));
    model_step();
    @(posedge clk);
    #1;
    chk("disp_data", int'(disp_data), m_disp);
    chk("disp_contr", int'(disp_contr), m_contr);
    chk("show_res", int'(show_res), int'(m_show));
  endtask

  task automatic idle_cycles(input int n);
    idle();
    repeat (n) cycle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    #1;
    chk("rst_disp_data", int'(disp_data), 0);
    chk("rst_disp_contr", int'(disp_contr), 0);
    chk("rst_show_res", int'(show_res), 0);
    chk("rst_res_ready", int'(res_ready), 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst_res_ready", int'(res_ready), 1);

    // Directed table: each entry starts with the display free and ends after the hold has run out.
    tbl.push_back('{1, 1234, 0, 0,     0, 0, 1234, 0, 0});
    tbl.push_back('{0, 0,    1, -25,   0, 0, 25,   1, 1});
    tbl.push_back('{0, 0,    1, -1000, 0, 0, 0,    2, 1});
    tbl.push_back('{0, 0,    1, 100,   1, 0, 0,    2, 1});
    tbl.push_back('{0, 0,    1, -5,    0, 1, 0,    2, 1});
    tbl.push_back('{0, 0,    1, 314,   0, 1, 314,  4, 1});
    tbl.push_back('{0, 0,    1, -2048, 0, 0, 0,    2, 1});
    tbl.push_back('{0, 0,    1, -999,  0, 0, 999,  1, 1});
    tbl.push_back('{0, 0,    1, 0,     0, 0, 0,    0, 1});
    tbl.push_back('{0, 0,    1, 2047,  0, 0, 2047, 0, 1});
    tbl.push_back('{1, 0,    0, 0,     0, 0, 0,    0, 0});
    foreach (tbl[i]) begin
      drive(tbl[i].ov, tbl[i].od, tbl[i].rv, tbl[i].rd, tbl[i].re, tbl[i].rf, 0);
      cycle();
      chk($sformatf("tbl%0d_disp", i), int'(disp_data), tbl[i].e_disp);
      chk($sformatf("tbl%0d_contr", i), int'(disp_contr), tbl[i].e_contr);
      chk($sformatf("tbl%0d_show", i), int'(show_res), int'(tbl[i].e_show));
      idle_cycles(H);
    end

    // Ready stays low for the counted-down part of the hold, then returns.
    drive(0, 0, 1, -25, 0, 0, 0);
    cycle();
    idle();
    low_cnt = 0;
    if (!res_ready) low_cnt++;
    for (int i = 0; i < H + 1; i++) begin
      cycle();
      if (!res_ready) low_cnt++;
    end
    chk("ready_low_cycles", low_cnt, H - 1);
    chk("ready_after_hold", int'(res_ready), 1);
    idle_cycles(2);

    // Two operands during a hold: newest one appears right after the hold runs out.
    drive(0, 0, 1, 314, 0, 1, 0);
    cycle();
    chk("frac_contr", int'(disp_contr), 4);
    drive(1, 7, 0, 0, 0, 0, 0);
    cycle();
    drive(1, 9, 0, 0, 0, 0, 0);
    cycle();
    idle_cycles(5);
    chk("hold_end_still_res", int'(disp_data), 314);
    idle_cycles(1);
    chk("pend_newest_disp", int'(disp_data), 9);
    chk("pend_newest_contr", int'(disp_contr), 0);
    chk("pend_newest_show", int'(show_res), 0);
    idle_cycles(2);

    // Simultaneous operand and result: result first, operand after the hold.
    drive(1, 5, 1, 12, 0, 0, 0);
    cycle();
    chk("simul_res", int'(disp_data), 12);
    idle_cycles(H - 1);
    chk("simul_res_held", int'(disp_data), 12);
    idle_cycles(1);
    chk("simul_op_after", int'(disp_data), 5);

    // clr on hold cycle 3 wipes the display and the pending operand, and refuses the offered result.
    drive(0, 0, 1, 50, 0, 0, 0);
    cycle();
    drive(1, 77, 0, 0, 0, 0, 0);
    cycle();
    idle_cycles(1);
    drive(0, 0, 1, 99, 0, 0, 1);
    #1;
    chk("clr_ready_low", int'(res_ready), 0);
    cycle();
    chk("clr_disp", int'(disp_data), 0);
    chk("clr_contr", int'(disp_contr), 0);
    chk("clr_show", int'(show_res), 0);
    idle_cycles(H + 2);
    chk("clr_no_pending", int'(disp_data), 0);

    // Asynchronous reset mid-hold discards result and pending operand.
    drive(0, 0, 1, -60, 0, 0, 0);
    cycle();
    drive(1, 88, 0, 0, 0, 0, 0);
    cycle();
    idle_cycles(1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_disp", int'(disp_data), 0);
    chk("arst_contr", int'(disp_contr), 0);
    chk("arst_show", int'(show_res), 0);
    chk("arst_ready", int'(res_ready), 1);
    #2;
    rst = 1'b0;
    idle_cycles(H + 2);
    chk("arst_no_pending", int'(disp_data), 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) x = int'($urandom_range(0, 4095));
      else x = int'($urandom_range(0, 2200)) - 1100;
      drive($urandom_range(0, 3) == 0, int'($urandom_range(0, 2047)),
            $urandom_range(0, 2) == 0, x,
            $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 24) == 0);
      cycle();
    end
    idle_cycles(H + 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
